// File: rtl/activation_pwl_pipe.sv
// -----------------------------------------------------------------------------
// activation_pwl_pipe
//
// Three-stage pipelined piecewise-linear activation unit (PLAN sigmoid, with
// tanh derived as 2*sigmoid(2x) - 1). A valid/ready handshake with backpressure
// sits on both sides. A sideband tag travels with each sample.
//
//   S1: |x| (doubled for tanh), sign, alignment to the output grid, segment class
//   S2: positive-half sigmoid p from the segment's slope/offset
//   S3: sign fold (1-p) and tanh remap; registered outputs
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   input sample valid
//   in_ready   block can accept a sample this cycle
//   in_x       signed input, IN_FRAC fractional bits
//   in_mode    0 = sigmoid, 1 = tanh
//   in_tag     sideband, passed through unchanged
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_y      signed result, OUT_FRAC fractional bits (1.0 = 2**OUT_FRAC)
//   out_tag    tag of the sample being output
//   out_sat    |effective x| >= 5.0, output is at a rail
// -----------------------------------------------------------------------------
module activation_pwl_pipe #(
    parameter int IN_WIDTH  = 8,
    parameter int IN_FRAC   = 4,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_FRAC  = 14,
    parameter int TAG_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_x,
    input  logic                        in_mode,
    input  logic [TAG_WIDTH-1:0]        in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_y,
    output logic [TAG_WIDTH-1:0]        out_tag,
    output logic                        out_sat
);

    // The slope shifts (down to /32) must land on whole output LSBs, and the
    // output needs a sign bit plus one integer bit to hold +/-1.0.
    if (OUT_FRAC < IN_FRAC + 5 || OUT_WIDTH < OUT_FRAC + 2) begin : g_param_check
        $error("activation_pwl_pipe: require OUT_FRAC >= IN_FRAC+5 and OUT_WIDTH >= OUT_FRAC+2");
    end

    localparam int SHIFT = OUT_FRAC - IN_FRAC;
    // Aligned magnitude: IN_WIDTH+1 for |x|, +1 for the tanh doubling.
    localparam int AW    = IN_WIDTH + 2 + SHIFT;
    // Compare width: wide enough for both the magnitude and the 5.0 threshold.
    localparam int CW    = (AW > OUT_FRAC + 4) ? AW : OUT_FRAC + 4;
    // Below 5.0 the magnitude fits in 3 integer bits; seg3 ignores it.
    localparam int PW    = OUT_FRAC + 3;
    // p and s live in [0, 1.0].
    localparam int QW    = OUT_FRAC + 1;

    localparam logic [CW-1:0] A_ONE    = CW'(64'd1  << OUT_FRAC);
    localparam logic [CW-1:0] A_2P375  = CW'(64'd19 << (OUT_FRAC - 3));
    localparam logic [CW-1:0] A_FIVE   = CW'(64'd5  << OUT_FRAC);
    localparam logic [QW-1:0] P_HALF   = QW'(64'd1  << (OUT_FRAC - 1));
    localparam logic [QW-1:0] P_5_8    = QW'(64'd5  << (OUT_FRAC - 3));
    localparam logic [QW-1:0] P_27_32  = QW'(64'd27 << (OUT_FRAC - 5));
    localparam logic [QW-1:0] P_ONE    = QW'(64'd1  << OUT_FRAC);
    localparam logic signed [OUT_WIDTH-1:0] Y_ONE = OUT_WIDTH'(64'd1 << OUT_FRAC);

    typedef enum logic [1:0] {
        SEG0 = 2'd0,   // a < 1.0
        SEG1 = 2'd1,   // 1.0 <= a < 2.375
        SEG2 = 2'd2,   // 2.375 <= a < 5.0
        SEG3 = 2'd3    // a >= 5.0, saturated
    } seg_t;

    // Pipeline registers
    logic                        s1_valid, s2_valid, s3_valid;
    logic                        s1_sign,  s2_sign;
    logic                        s1_mode,  s2_mode;
    logic [TAG_WIDTH-1:0]        s1_tag,   s2_tag,   s3_tag;
    seg_t                        s1_seg;
    logic [PW-1:0]               s1_a;
    logic [QW-1:0]               s2_p;
    logic                        s2_sat,   s3_sat;
    logic signed [OUT_WIDTH-1:0] s3_y;

    // Combinational stage inputs
    logic                        advance;
    logic [IN_WIDTH:0]           x_ext;
    logic [IN_WIDTH:0]           x_abs;
    logic [IN_WIDTH+1:0]         x_mag;
    logic [CW-1:0]               a_cmp;
    seg_t                        seg_next;
    logic [QW-1:0]               p_next;
    logic [QW-1:0]               s_mag;
    logic signed [OUT_WIDTH-1:0] s_ext;
    logic signed [OUT_WIDTH-1:0] y_next;

    // All stages move in lockstep; S3 frees up when empty or being consumed.
    assign advance  = !s3_valid || out_ready;
    // Gated by reset so the block advertises nothing while held in reset.
    assign in_ready = reset && advance;

    // ---------------- S1: magnitude, alignment, segment ----------------
    // One extra bit makes |-2^(IN_WIDTH-1)| representable.
    assign x_ext = {in_x[IN_WIDTH-1], in_x};
    assign x_abs = in_x[IN_WIDTH-1] ? -x_ext : x_ext;
    assign x_mag = in_mode ? {x_abs, 1'b0} : {1'b0, x_abs};
    assign a_cmp = CW'({x_mag, {SHIFT{1'b0}}});

    always_comb begin
        // NOTE: every variable written in always_comb gets a default first so
        // that no path leaves it unassigned and a latch is never inferred.
        seg_next = SEG3;
        if (a_cmp < A_ONE)        seg_next = SEG0;
        else if (a_cmp < A_2P375) seg_next = SEG1;
        else if (a_cmp < A_FIVE)  seg_next = SEG2;
    end

    // ---------------- S2: positive-half sigmoid ----------------
    // Each shifted term stays below the segment's span, so truncating to QW
    // bits drops only zero bits.
    always_comb begin
        p_next = P_ONE;
        case (s1_seg)
            SEG0:    p_next = QW'(s1_a >> 2) + P_HALF;
            SEG1:    p_next = QW'(s1_a >> 3) + P_5_8;
            SEG2:    p_next = QW'(s1_a >> 5) + P_27_32;
            default: p_next = P_ONE;
        endcase
    end

    // ---------------- S3: sign fold and tanh remap ----------------
    assign s_mag = s2_sign ? (P_ONE - s2_p) : s2_p;
    assign s_ext = {{(OUT_WIDTH - QW){1'b0}}, s_mag};
    // 2s can reach 2.0, which wraps in the minimum output width; the wrap
    // cancels after subtracting 1.0 because the true result is in [-1, 1].
    assign y_next = s2_mode ? ((s_ext <<< 1) - Y_ONE) : s_ext;

    // ---------------- Pipeline registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mode  <= 1'b0;
            s1_tag   <= '0;
            s1_seg   <= SEG0;
            s1_a     <= '0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mode  <= 1'b0;
            s2_tag   <= '0;
            s2_p     <= '0;
            s2_sat   <= 1'b0;
            s3_valid <= 1'b0;
            s3_tag   <= '0;
            s3_y     <= '0;
            s3_sat   <= 1'b0;
        end else if (advance) begin
            // NOTE: non-blocking assignments here so every stage samples the
            // previous stage's pre-edge value, whatever the statement order.
            s1_valid <= in_valid;
            s1_sign  <= in_x[IN_WIDTH-1];
            s1_mode  <= in_mode;
            s1_tag   <= in_tag;
            s1_seg   <= seg_next;
            s1_a     <= a_cmp[PW-1:0];

            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mode  <= s1_mode;
            s2_tag   <= s1_tag;
            s2_p     <= p_next;
            s2_sat   <= (s1_seg == SEG3);

            s3_valid <= s2_valid;
            s3_tag   <= s2_tag;
            s3_y     <= y_next;
            s3_sat   <= s2_sat;
        end
    end

    assign out_valid = s3_valid;
    assign out_y     = s3_y;
    assign out_tag   = s3_tag;
    assign out_sat   = s3_sat;

endmodule

// File: doc/activation_pwl_pipe.md
Name: activation_pwl_pipe

Overview:
Parametrised, pipelined piecewise-linear activation unit. Successor to the single-function sigmoid block.
- Adds a per-sample mode select: sigmoid or tanh.
- Adds a valid/ready stream handshake with backpressure.
- Carries a sideband tag so a neuron or channel index travels with each sample.
- Sits between the MAC accumulator output and the layer writeback buffer.

Parameters:
IN_WIDTH, 8, input width; signed fixed point.
IN_FRAC, 4, input fractional bits. Default format Q3.4, range -8.0 .. +7.9375.
OUT_WIDTH, 16, output width; signed fixed point.
OUT_FRAC, 14, output fractional bits; 1.0 = 16384 at default. Elaboration must fail unless OUT_FRAC >= IN_FRAC+5 and OUT_WIDTH >= OUT_FRAC+2.
TAG_WIDTH, 4, sideband tag width.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample this cycle
in_x  in  IN_WIDTH  signed input
in_mode  in  1  0 = sigmoid, 1 = tanh
in_tag  in  TAG_WIDTH  sideband, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_y  out  OUT_WIDTH  signed result in Q(OUT_WIDTH-OUT_FRAC).OUT_FRAC
out_tag  out  TAG_WIDTH  tag of the sample being output
out_sat  out  1  |effective x| >= 5.0; the output is at a rail

Behaviour:
- Reset (reset low, asynchronous): all stage valid bits cleared. out_valid=0, out_y=0, out_tag=0, out_sat=0, in_ready=0 while reset is asserted. in_ready=1 in the first cycle after release.
- Pipeline: three registered stages S1 -> S2 -> S3; S3 drives the outputs.
- Latency: an accepted sample appears on out_y exactly 3 cycles after acceptance, provided no stall occurs.
- Throughput: 1 sample per cycle when out_ready=1.
- Stall rule: advance = !S3.valid || out_ready. All stages shift together only when advance=1; in_ready = advance.
  - Bubbles are not compressed.
  - A sample is accepted when in_valid && in_ready.
  - If in_valid=0 on an advancing cycle, a bubble (valid=0) enters S1.
- Output hold: while out_valid=1 and out_ready=0, out_y, out_tag and out_sat are held stable. No sample is lost or duplicated.
- S1:
  - a = |in_x|, computed at IN_WIDTH+1 bits so that |-2^(IN_WIDTH-1)| is exact.
  - If tanh mode: a = 2a.
  - Record sign = in_x < 0.
  - Align a to OUT_FRAC fractional bits by a left shift of (OUT_FRAC-IN_FRAC).
  - Classify the segment of a:
    - seg0: a < 1.0
    - seg1: 1.0 <= a < 2.375
    - seg2: 2.375 <= a < 5.0
    - seg3: a >= 5.0
- S2: p = positive-half sigmoid approximation (PLAN):
  - seg0: a/4 + 0.5
  - seg1: a/8 + 0.625
  - seg2: a/32 + 0.84375
  - seg3: 1.0
  - Slopes are arithmetic right shifts. All terms are exact given the OUT_FRAC constraint.
- S3:
  - s = sign ? (1.0 - p) : p.
  - sigmoid mode: y = s.
  - tanh mode: y = 2s - 1.0.
  - out_sat = seg3.
  - No rounding anywhere. Results always lie in [-1.0, +1.0], so no overflow is possible.
- Mode and tag travel with their sample through every stage. Mixed-mode back-to-back samples are legal.
- Reset mid-stream: all in-flight samples are discarded. No output pulse follows reset release until new samples are accepted.

Test Plan:
- Reset, then sigmoid mode, out_ready=1, in_x = 0, 16, -16, 4, 48, 127, -128 on consecutive cycles -> out_y = 8192, 12288, 4096, 9216, 15360, 16384, 0, starting 3 cycles after the first acceptance. out_sat=1 only for the last two outputs.
- Tanh mode, in_x = 0, 8, -8, -128 -> out_y = 0, 8192, -8192, -16384. out_sat=1 only for -128.
- Alternating mode with tags 0..7, in_x=16: sigmoid -> 12288; tanh -> 2*sig(2.0)-1 = 2*0.875-1 = 0.75 -> 12288. Check out_tag order is 0..7 and out_tag matches each sample.
- Backpressure: stream 5 samples with out_ready=0 from cycle 2 for 4 cycles:
  - in_ready drops the cycle S3 becomes valid.
  - out_y holds constant throughout the stall.
  - After release, all 5 outputs appear in order with no loss or duplication.
- Reset asserted asynchronously mid-cycle with 3 samples in flight -> out_valid falls immediately and out_y becomes 0. After release, out_valid stays 0 until new input; in_ready=1.
- Sweep all 256 inputs × both modes -> compare against a bit-exact reference model. Check monotonic non-decreasing output vs in_x for each mode.
